// File: rtl/alu_display_driver.sv
// rtl/alu_display_driver.sv - captures one ALU result and multiplexes it onto a two-digit 7-segment display
// Error results show "Er" blinking; an empty display shows dashes.
module alu_display_driver #(
  parameter int REFRESH_DIV = 1000,
  parameter int HOLD_CYCLES = 16,
  parameter int BLINK_DIV   = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] dec_bcd,
  input  logic [3:0] unit_bcd,
  input  logic       zero_in,
  input  logic       error_in,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       zero_led,
  output logic       err_led
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SHOW} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] ref_cnt;
  logic [BW-1:0] blink_cnt;
  logic          dig_sel;
  logic          blink_ph;
  logic [3:0]    tens_q;
  logic [3:0]    units_q;
  logic          zero_q;
  logic          err_q;
  logic [6:0]    seg_raw;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction

  assign in_ready = ena && (state != S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      ref_cnt   <= '0;
      blink_cnt <= '0;
      dig_sel   <= 1'b0;
      blink_ph  <= 1'b0;
      tens_q    <= '0;
      units_q   <= '0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (ena) begin
      if (ref_cnt == REF_MAX) begin
        ref_cnt <= '0;
        dig_sel <= ~dig_sel;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end

      if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_MAX) begin
            state    <= S_SHOW;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          // Capture restarts the blink so an error always opens visible.
          if (in_valid) begin
            state     <= S_HOLD;
            hold_cnt  <= '0;
            tens_q    <= dec_bcd;
            units_q   <= unit_bcd;
            zero_q    <= zero_in;
            err_q     <= error_in || (dec_bcd > 4'd9) || (unit_bcd > 4'd9);
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    seg_raw = 7'h40;
    if (state != S_IDLE) begin
      if (err_q) begin
        seg_raw = blink_ph ? 7'h00 : (dig_sel ? 7'h79 : 7'h50);
      end else if (dig_sel) begin
        seg_raw = (tens_q == 4'd0) ? 7'h00 : enc(tens_q);
      end else begin
        seg_raw = enc(units_q);
      end
    end
  end

  assign seg      = ena ? seg_raw : 7'h00;
  assign dig_en   = ena ? (dig_sel ? 2'b10 : 2'b01) : 2'b00;
  assign zero_led = zero_q && !err_q;
  assign err_led  = err_q;

endmodule

// File: tb/tb_alu_display_driver.sv
// tb/tb_alu_display_driver.sv - randomized scoreboard bench for alu_display_driver
module tb_alu_display_driver;

  localparam int R = 4;
  localparam int H = 3;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] dec_bcd = 4'd0;
  logic [3:0] unit_bcd = 4'd0;
  logic       zero_in = 1'b0;
  logic       error_in = 1'b0;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       zero_led;
  logic       err_led;

  int checks = 0;
  int errors = 0;

  alu_display_driver #(.REFRESH_DIV(R), .HOLD_CYCLES(H), .BLINK_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .dec_bcd(dec_bcd), .unit_bcd(unit_bcd), .zero_in(zero_in), .error_in(error_in),
    .seg(seg), .dig_en(dig_en), .zero_led(zero_led), .err_led(err_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] t_seg;
    logic [6:0] u_seg;
    logic       zero;
    logic       err;
  } rec_t;

  rec_t q[$];
  logic [6:0] enc_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference: 0 idle, 1 hold, 2 show; counters are enabled cycles since reset / since capture.
  int   m_state = 0;
  int   m_left = 0;
  int   m_rcnt = 0;
  int   m_bcnt = 0;
  rec_t m_rec = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_left = 0; m_rcnt = 0; m_bcnt = 0;
      m_rec = '{default: '0};
    end else if (ena) begin
      int prev;
      prev = m_state;
      m_rcnt++;
      m_bcnt++;
      if (prev == 1) begin
        m_left--;
        if (m_left == 0) m_state = 2;
      end else if (in_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty: transfer with no expected record");
        end else begin
          m_rec = q.pop_front();
        end
        m_state = 1;
        m_left  = H;
        m_bcnt  = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int e_seg, e_dig;
    bit sel, ph;
    #2;
    sel = ((m_rcnt / R) % 2) == 1;
    ph  = ((m_bcnt / B) % 2) == 1;
    if (!ena) begin
      e_seg = 0; e_dig = 0;
    end else begin
      e_dig = sel ? 2 : 1;
      if (m_state == 0)             e_seg = 'h40;
      else if (m_rec.err && ph)     e_seg = 0;
      else                          e_seg = sel ? int'(m_rec.t_seg) : int'(m_rec.u_seg);
    end
    chk("in_ready", int'(in_ready), int'(ena && m_state != 1));
    chk("seg", int'(seg), e_seg);
    chk("dig_en", int'(dig_en), e_dig);
    chk("zero_led", int'(zero_led), int'(m_rec.zero));
    chk("err_led", int'(err_led), int'(m_rec.err));
  end

  // Caller is at a falling edge; returns at the falling edge after acceptance with in_valid still high.
  task automatic send(input logic [3:0] d, input logic [3:0] u, input logic z, input logic e);
    rec_t r;
    bit ok;
    r.err   = e || (d > 9) || (u > 9);
    r.t_seg = r.err ? 7'h79 : ((d == 0) ? 7'h00 : enc_tab[d]);
    r.u_seg = r.err ? 7'h50 : enc_tab[u];
    r.zero  = z && !r.err;
    dec_bcd = d; unit_bcd = u; zero_in = z; error_in = e; in_valid = 1'b1;
    q.push_back(r);
    ok = 0;
    #3;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
      #3;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready never rose for dec=%0d unit=%0d", d, u);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_send();
    logic [3:0] d, u;
    d = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    u = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    send(d, u, 1'($urandom_range(0, 1)), ($urandom_range(0, 6) == 0));
  endtask

  initial begin
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    send(4'd2, 4'd7, 1'b0, 1'b0);  idle(20);
    send(4'd0, 4'd0, 1'b1, 1'b0);  idle(20);
    send(4'd3, 4'd1, 1'b0, 1'b1);  idle(40);
    send(4'd5, 4'hC, 1'b1, 1'b0);  idle(30);

    // Back-to-back: second item is presented while the first is still holding.
    send(4'd9, 4'd8, 1'b0, 1'b0);
    send(4'd1, 4'd4, 1'b0, 1'b0);
    send(4'd6, 4'd0, 1'b1, 1'b0);  idle(12);

    send(4'd4, 4'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    ena = 1'b0;
    repeat (10) @(negedge clk);
    ena = 1'b1;
    idle(15);

    send(4'd7, 4'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(4'd8, 4'd5, 1'b0, 1'b0);  idle(10);

    for (int k = 0; k < 60; k++) begin
      rand_send();
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        ena = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        ena = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 25));
    end
    idle(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
